// File: rtl/led_ctrl_pkg.sv
// Shared constants for the LED toggle controller and its per-channel debouncers.
package led_ctrl_pkg;

  localparam int unsigned N_CH_DEFAULT     = 4;
  localparam int unsigned DEBOUNCE_DEFAULT = 50000;

  // Electrical polarity of the board: LEDs and buttons are both active-low.
  localparam logic LED_OFF      = 1'b1;
  localparam logic BTN_RELEASED = 1'b1;

  // Counter width for a debounce window; always holds DebounceCycles-1.
  function automatic int unsigned deb_cnt_width(input int unsigned debounce_cycles);
    return (debounce_cycles < 2) ? 1 : $clog2(debounce_cycles);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchronizer, counter debouncer and press strobe.
// press_o is the combinational accept-of-press strobe; the caller registers it.
module btn_debounce
  import led_ctrl_pkg::*;
#(
  parameter int unsigned DebounceCycles = DEBOUNCE_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_n_i,
  output logic stable_o,
  output logic press_o
);

  localparam int unsigned CntW = deb_cnt_width(DebounceCycles);
  localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

  logic            sync1_q, sync2_q;
  logic            stable_q, stable_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            accept;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q  <= BTN_RELEASED;
      sync2_q  <= BTN_RELEASED;
      stable_q <= BTN_RELEASED;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= btn_n_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // Any cycle where the synchronized level agrees with stable restarts the window.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    accept   = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CntMax) begin
        accept   = 1'b1;
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  assign stable_o = stable_q;
  assign press_o  = accept && (stable_q == BTN_RELEASED);

endmodule

// File: rtl/led_toggle_ctrl.sv
// Debounced push-button LED toggler: each accepted press flips its LED,
// i_clr_all darkens every LED; press pulses are registered alongside the toggle.
module led_toggle_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned N_CH            = N_CH_DEFAULT
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [N_CH-1:0] i_btn_n,
  input  logic            i_clr_all,
  output logic [N_CH-1:0] o_led_n,
  output logic [N_CH-1:0] o_press
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_param
    $error("DEBOUNCE_CYCLES must be at least 2");
  end

  logic [N_CH-1:0] stable;
  logic [N_CH-1:0] press_strobe;
  logic [N_CH-1:0] led_q, led_d;
  logic [N_CH-1:0] press_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    btn_debounce #(
      .DebounceCycles(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
      .clk_i   (i_clk),
      .rst_ni  (i_rst_n),
      .btn_n_i (i_btn_n[g]),
      .stable_o(stable[g]),
      .press_o (press_strobe[g])
    );

    // A press strobe is only legal on the edge that leaves the released level.
    always_comb begin
      if (press_strobe[g]) begin
        assert (stable[g] == BTN_RELEASED);
      end
    end
  end

  // Clear wins over a coincident toggle; the press pulse itself is unaffected.
  always_comb begin
    led_d = led_q ^ press_strobe;
    if (i_clr_all) begin
      led_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      led_q   <= '0;
      press_q <= '0;
    end else begin
      led_q   <= led_d;
      press_q <= press_strobe;
    end
  end

  always_comb begin
    o_led_n = '0;
    for (int i = 0; i < N_CH; i++) begin
      o_led_n[i] = led_q[i] ? ~LED_OFF : LED_OFF;
    end
  end

  assign o_press = press_q;

endmodule

// File: tb/tb_led_toggle_ctrl.sv
// Directed bench for led_toggle_ctrl with a 4-cycle debounce window.
module tb_led_toggle_ctrl;

  localparam int unsigned Deb = 4;
  localparam int unsigned NCh = 4;

  logic           clk;
  logic           rst_n;
  logic [NCh-1:0] btn_n;
  logic           clr_all;
  logic [NCh-1:0] led_n;
  logic [NCh-1:0] press;

  int total;
  int bad;

  led_toggle_ctrl #(
    .DEBOUNCE_CYCLES(Deb),
    .N_CH           (NCh)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_btn_n  (btn_n),
    .i_clr_all(clr_all),
    .o_led_n  (led_n),
    .o_press  (press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  btn;
    logic        clr;
    int unsigned cycles;
    logic [3:0]  exp_led_n;
    logic [3:0]  exp_press;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] b, input logic c, input int unsigned n,
                     input logic [3:0] el, input logic [3:0] ep);
    vec_t v;
    v.btn = b; v.clr = c; v.cycles = n; v.exp_led_n = el; v.exp_press = ep;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_both(input string tag, input logic [3:0] el, input logic [3:0] ep);
    check({tag, " led_n"}, led_n, el);
    check({tag, " press"}, press, ep);
  endtask

  // Hold btn for n edges; press expected only on the last one.
  task automatic hold_and_expect(input string tag, input logic [3:0] b, input int unsigned n,
                                 input logic [3:0] el_before, input logic [3:0] el_after,
                                 input logic [3:0] ep_last);
    btn_n = b;
    for (int i = 1; i <= int'(n); i++) begin
      step();
      if (i == int'(n)) check_both($sformatf("%s step%0d", tag, i), el_after, ep_last);
      else              check_both($sformatf("%s step%0d", tag, i), el_before, 4'b0000);
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    btn_n   = 4'b1111;
    clr_all = 1'b0;

    // Idle, single press / release / re-press on bit 0
    add(4'b1111, 1'b0, 20, 4'b1111, 4'b0000);
    add(4'b1110, 1'b0, 5,  4'b1111, 4'b0000);
    add(4'b1110, 1'b0, 1,  4'b1110, 4'b0001);
    add(4'b1110, 1'b0, 14, 4'b1110, 4'b0000);
    add(4'b1111, 1'b0, 10, 4'b1110, 4'b0000);
    add(4'b1110, 1'b0, 5,  4'b1110, 4'b0000);
    add(4'b1110, 1'b0, 1,  4'b1111, 4'b0001);
    add(4'b1110, 1'b0, 4,  4'b1111, 4'b0000);
    add(4'b1111, 1'b0, 10, 4'b1111, 4'b0000);
    // Glitches on bit 2 shorter than the window
    for (int r = 0; r < 5; r++) begin
      add(4'b1011, 1'b0, 3, 4'b1111, 4'b0000);
      add(4'b1111, 1'b0, 3, 4'b1111, 4'b0000);
    end
    add(4'b1111, 1'b0, 6,   4'b1111, 4'b0000);
    // Simultaneous bits 1 and 3, long hold
    add(4'b0101, 1'b0, 5,   4'b1111, 4'b0000);
    add(4'b0101, 1'b0, 1,   4'b0101, 4'b1010);
    add(4'b0101, 1'b0, 100, 4'b0101, 4'b0000);
    add(4'b1111, 1'b0, 10,  4'b0101, 4'b0000);
    // Light the rest, then clear coinciding with a bit 0 acceptance
    add(4'b1010, 1'b0, 5,  4'b0101, 4'b0000);
    add(4'b1010, 1'b0, 1,  4'b0000, 4'b0101);
    add(4'b1111, 1'b0, 10, 4'b0000, 4'b0000);
    add(4'b1110, 1'b0, 5,  4'b0000, 4'b0000);
    add(4'b1110, 1'b1, 1,  4'b1111, 4'b0001);
    add(4'b1111, 1'b0, 10, 4'b1111, 4'b0000);
    // Clear during a bit 1 debounce window must not disturb the count
    add(4'b1101, 1'b1, 3,  4'b1111, 4'b0000);
    add(4'b1101, 1'b0, 2,  4'b1111, 4'b0000);
    add(4'b1101, 1'b0, 1,  4'b1101, 4'b0010);
    add(4'b1101, 1'b0, 3,  4'b1101, 4'b0000);
    add(4'b1111, 1'b0, 10, 4'b1101, 4'b0000);
    add(4'b1111, 1'b1, 1,  4'b1111, 4'b0000);
    add(4'b1111, 1'b0, 2,  4'b1111, 4'b0000);

    #12;
    check_both("in reset", 4'b1111, 4'b0000);
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      btn_n   = vecs[k].btn;
      clr_all = vecs[k].clr;
      for (int c = 0; c < int'(vecs[k].cycles); c++) begin
        step();
        check_both($sformatf("vec%0d cyc%0d", k, c), vecs[k].exp_led_n, vecs[k].exp_press);
      end
    end
    clr_all = 1'b0;

    // Reset mid-debounce on bit 3, with bit 0 lit beforehand
    hold_and_expect("lit0", 4'b1110, 6, 4'b1111, 4'b1110, 4'b0001);
    hold_and_expect("rel0", 4'b1111, 10, 4'b1110, 4'b1110, 4'b0000);
    hold_and_expect("pre3", 4'b0111, 4, 4'b1110, 4'b1110, 4'b0000);
    #2;
    rst_n = 1'b0;
    #1;
    check_both("async rst mid-debounce", 4'b1111, 4'b0000);
    step();
    check_both("rst held", 4'b1111, 4'b0000);
    rst_n = 1'b1;
    hold_and_expect("post3", 4'b0111, 6, 4'b1111, 4'b0111, 4'b1000);
    step();
    check_both("post3 pulse end", 4'b0111, 4'b0000);

    // Reset while a press pulse is high; bit 0 still held counts as new press
    hold_and_expect("rel3", 4'b1111, 10, 4'b0111, 4'b0111, 4'b0000);
    hold_and_expect("p0", 4'b1110, 6, 4'b0111, 4'b0110, 4'b0001);
    rst_n = 1'b0;
    #1;
    check_both("async rst mid-pulse", 4'b1111, 4'b0000);
    step();
    rst_n = 1'b1;
    hold_and_expect("post0", 4'b1110, 6, 4'b1111, 4'b1110, 4'b0001);
    step();
    check_both("post0 pulse end", 4'b1110, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_toggle_ctrl.md
LED_TOGGLE_CTRL -- requirements
Module: led_toggle_ctrl

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 50000, consecutive stable cycles required to accept a button level change; legal range >= 2.
REQ-002 Parameter: N_CH, default 4, number of button/LED channels.
REQ-003 Port: i_clk  input  1  the block's one clock; all state updates on its rising edge.
REQ-004 Port: i_rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port: i_btn_n  input  N_CH  raw, asynchronous button levels; 0 = pressed, 1 = released (K1, K4, K7, K10 map to bits 0..3).
REQ-006 Port: i_clr_all  input  1  synchronous request to turn all LEDs off.
REQ-007 Port: o_led_n  output  N_CH  LED drive; 0 = lit, 1 = dark (L0..L3 map to bits 0..3).
REQ-008 Port: o_press  output  N_CH  one-cycle pulse per accepted press, per channel.

Function
REQ-009 Each i_btn_n bit SHALL pass through a 2-flop synchronizer (sync1, sync2) before any other use.
REQ-010 Each channel SHALL hold a debounced level "stable" and a counter cnt of width $clog2(DEBOUNCE_CYCLES).
REQ-011 When sync2 == stable, cnt SHALL be cleared to 0 on that edge.
REQ-012 When sync2 != stable and cnt < DEBOUNCE_CYCLES-1, cnt SHALL increment by 1.
REQ-013 When sync2 != stable and cnt == DEBOUNCE_CYCLES-1, stable SHALL take sync2 and cnt SHALL clear to 0 on the same edge.
REQ-014 A stable transition 1->0 SHALL set o_press for exactly one cycle, registered on the same edge as the stable update; a 0->1 transition SHALL produce no pulse.
REQ-015 Latency: with i_btn_n held low from sampling edge 0, o_press SHALL be high after edge DEBOUNCE_CYCLES+1 and low after edge DEBOUNCE_CYCLES+2.
REQ-016 A channel's LED state SHALL toggle on the same edge its o_press is set. The LED is lit when its state is 1, and o_led_n = ~state.
REQ-017 A level disturbance shorter than DEBOUNCE_CYCLES consecutive synchronized cycles SHALL NOT change stable, o_press or the LED.
REQ-018 A button held pressed SHALL produce exactly one o_press, with no auto-repeat. A new press requires an accepted release first.
REQ-019 Channels SHALL operate independently. Simultaneous presses on several channels SHALL each pulse and toggle on the same edge.
REQ-020 i_clr_all = 1 SHALL force all LED states to 0 on that edge. If clear and a press coincide, clear SHALL win for the LED, and o_press SHALL still pulse.
REQ-021 i_clr_all SHALL NOT affect the synchronizers, stable, or cnt.
REQ-022 cnt SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.

Reset
REQ-023 While i_rst_n = 0, the following SHALL hold asynchronously: sync1 = sync2 = stable = 1, cnt = 0, LED state = 0, o_led_n = all 1s (dark), o_press = 0.
REQ-024 Reset asserted mid-debounce or mid-pulse SHALL abort the operation. After release, a button still held low SHALL be treated as a new press, pulsing after DEBOUNCE_CYCLES+2 edges.

Structure
REQ-025 The shared package led_ctrl_pkg SHALL hold N_CH_DEFAULT = 4, DEBOUNCE_DEFAULT = 50000, and LED_OFF = 1 / BTN_RELEASED = 1 constants.
REQ-026 The per-channel synchronizer, debouncer and press detection SHALL be in a sub-module btn_debounce (ports: clock, reset, raw level, stable level, press pulse). It SHALL be instanced N_CH times by generate.
REQ-027 LED toggle and clear logic SHALL reside in led_toggle_ctrl.

Verification (DEBOUNCE_CYCLES = 4)
REQ-028 Reset, then i_btn_n = 1111 for 20 cycles -> o_led_n = 1111 and o_press = 0000 throughout.
REQ-029 Bit 0 goes low at edge 0 and is held for 20 cycles -> o_press = 0001 only in the cycle after edge 5. o_led_n = 1110 from edge 5 on. Then release for 10 cycles and press again -> o_led_n returns to 1111.
REQ-030 Bit 2 goes low for 3 cycles and then high, repeated 5 times -> no o_press, and o_led_n stays 1111.
REQ-031 Bits 1 and 3 go low on the same edge -> o_press = 1010 for one cycle, then o_led_n = 0101. Holding them 100 cycles gives no further pulses.
REQ-032 LEDs are 0000 lit (o_led_n = 0000), and i_clr_all is asserted on the same edge as a bit 0 press acceptance -> o_press = 0001 and o_led_n = 1111.
REQ-033 i_rst_n is pulsed low at cnt = 2 while bit 3 is held low -> outputs immediately go to 1111/0000. After release, o_press = 1000 six edges later.
